// File: rtl/hpu_pkg.sv
// rtl/hpu_pkg.sv - shared execution-pipeline sizing for exe_ctrl and out_ctrl
package hpu_pkg;

  localparam int HPU_DW    = 32;
  localparam int HPU_ROWS  = 4;
  localparam int HPU_DEPTH = 2;

  // Row counter width; kept here so exe_ctrl and out_ctrl agree on the i-loop size.
  localparam int HPU_ROW_W = (HPU_ROWS > 1) ? $clog2(HPU_ROWS) : 1;

endpackage

// File: rtl/fifo_sync.sv
// rtl/fifo_sync.sv - synchronous register-array FIFO with occupancy count
module fifo_sync
  import hpu_pkg::*;
#(
  parameter int DW    = HPU_DW,
  parameter int DEPTH = HPU_DEPTH,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  // Callers gate push against full themselves, so push here is always accepted.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign rdata = mem[rptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/out_ctrl.sv
// rtl/out_ctrl.sv - row result buffer, credit back-pressure and batch completion
module out_ctrl
  import hpu_pkg::*;
#(
  parameter int DW    = HPU_DW,
  parameter int ROWS  = HPU_ROWS,
  parameter int DEPTH = HPU_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          k_init,
  input  logic          k_fin,
  input  logic [DW-1:0] k_data,
  output logic          out_busy,
  output logic          out_fin,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic          ovf
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = (ROWS == HPU_ROWS) ? HPU_ROW_W : $clog2(ROWS);
  localparam logic [CW:0]   CREDITS  = (CW + 1)'(DEPTH);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  logic [CW-1:0] count;
  logic [CW:0]   credit_use;
  logic [RW-1:0] row;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          inflight;

  fifo_sync #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (k_data),
    .rdata (m_data),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign m_valid = !empty;
  assign pop     = m_valid & m_ready;
  assign push    = k_fin & (!full | pop);
  assign m_last  = m_valid & (row == LAST_ROW);

  // Registers only: upstream gates k_init on out_busy, so no input may reach it.
  assign credit_use = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign out_busy   = (credit_use >= CREDITS);

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 1'b0;
      row      <= '0;
      out_fin  <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (k_init)     inflight <= 1'b1;
      else if (k_fin) inflight <= 1'b0;
      if (pop) row <= (row == LAST_ROW) ? '0 : row + RW'(1);
      out_fin <= pop & m_last;
      if (k_fin & ((full & !pop) | !inflight)) ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_out_ctrl.sv
// tb/tb_out_ctrl.sv - scoreboard bench for out_ctrl
module tb_out_ctrl;
  import hpu_pkg::*;

  localparam int DW   = HPU_DW;
  localparam int ROWS = HPU_ROWS;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          k_init = 1'b0;
  logic          k_fin = 1'b0;
  logic [DW-1:0] k_data = '0;
  logic          m_ready = 1'b0;
  logic          out_busy;
  logic          out_fin;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          ovf;

  exp_t sb_q[$];
  exp_t mon_e;
  int   sb_row   = 0;
  int   pass_cnt = 0;
  int   chk_cnt  = 0;
  int   fin_seen = 0;
  logic fin_pend = 1'b0;
  logic rst_prev = 1'b1;

  out_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .k_init   (k_init),
    .k_fin    (k_fin),
    .k_data   (k_data),
    .out_busy (out_busy),
    .out_fin  (out_fin),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_last   (m_last),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  // Scoreboard side: every accepted output word is matched against the expected queue.
  always @(negedge clk) begin
    chk_cnt++;
    if (out_fin !== (rst_prev ? 1'b0 : fin_pend))
      $display("FAIL out_fin got=%b exp=%b t=%0t", out_fin, rst_prev ? 1'b0 : fin_pend, $time);
    else pass_cnt++;
    if (out_fin) fin_seen++;
    fin_pend = 1'b0;
    if (m_valid && m_ready) begin
      chk_cnt++;
      if (sb_q.size() == 0) begin
        $display("FAIL unexpected_pop got=%h exp=none", m_data);
      end else begin
        mon_e = sb_q.pop_front();
        if (m_data !== mon_e.data || m_last !== mon_e.last)
          $display("FAIL stream_word got=%h/%b exp=%h/%b", m_data, m_last, mon_e.data, mon_e.last);
        else pass_cnt++;
        fin_pend = mon_e.last;
      end
    end
    rst_prev = rst;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_row(input logic [DW-1:0] d);
    exp_t e;
    e.data = d;
    e.last = (sb_row == ROWS - 1);
    sb_q.push_back(e);
    sb_row = (sb_row + 1) % ROWS;
  endtask

  task automatic push_row(input logic [DW-1:0] d);
    k_init = 1'b1;
    step();
    k_init = 1'b0;
    k_fin  = 1'b1;
    k_data = d;
    expect_row(d);
    step();
    k_fin = 1'b0;
  endtask

  task automatic do_reset();
    m_ready = 1'b0;
    k_init  = 1'b0;
    k_fin   = 1'b0;
    rst     = 1'b1;
    step();
    rst = 1'b0;
    sb_q.delete();
    sb_row = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    chk_cnt++; if (m_valid !== 1'b0)  $display("FAIL reset_m_valid got=%b exp=0", m_valid);   else pass_cnt++;
    chk_cnt++; if (out_busy !== 1'b0) $display("FAIL reset_out_busy got=%b exp=0", out_busy); else pass_cnt++;
    chk_cnt++; if (ovf !== 1'b0)      $display("FAIL reset_ovf got=%b exp=0", ovf);           else pass_cnt++;
    chk_cnt++; if (m_last !== 1'b0)   $display("FAIL reset_m_last got=%b exp=0", m_last);     else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_single_batch();
    logic [DW-1:0] d;
    int f0;
    do_reset();
    m_ready = 1'b1;
    f0 = fin_seen;
    for (int r = 0; r < ROWS; r++) begin
      d = DW'(32'h10 + r);
      k_init = 1'b1;
      step();
      k_init = 1'b0;
      repeat (7) step();
      k_fin  = 1'b1;
      k_data = d;
      expect_row(d);
      #2;
      chk_cnt++; if (m_valid !== 1'b0) $display("FAIL no_bypass got=%b exp=0", m_valid); else pass_cnt++;
      step();
      k_fin = 1'b0;
      chk_cnt++;
      if (m_valid !== 1'b1 || m_data !== d) $display("FAIL latency got=%b/%h exp=1/%h", m_valid, m_data, d);
      else pass_cnt++;
    end
    repeat (3) step();
    chk_cnt++; if (fin_seen - f0 != 1) $display("FAIL single_fin_count got=%0d exp=1", fin_seen - f0); else pass_cnt++;
    chk_cnt++; if (ovf !== 1'b0) $display("FAIL single_ovf got=%b exp=0", ovf); else pass_cnt++;
    chk_cnt++; if (sb_q.size() != 0) $display("FAIL single_drain got=%0d exp=0", sb_q.size()); else pass_cnt++;
  endtask

  task automatic test_back_pressure();
    logic ok;
    do_reset();
    push_row(DW'(32'h10));
    chk_cnt++; if (out_busy !== 1'b0) $display("FAIL bp_busy_one got=%b exp=0", out_busy); else pass_cnt++;
    k_init = 1'b1;
    step();
    k_init = 1'b0;
    chk_cnt++; if (out_busy !== 1'b1) $display("FAIL bp_busy_credit got=%b exp=1", out_busy); else pass_cnt++;
    k_fin  = 1'b1;
    k_data = DW'(32'h11);
    expect_row(k_data);
    step();
    k_fin = 1'b0;
    ok = 1'b1;
    repeat (20) begin
      step();
      if (out_busy !== 1'b1 || m_valid !== 1'b1 || m_data !== DW'(32'h10)) ok = 1'b0;
    end
    chk_cnt++; if (ok !== 1'b1) $display("FAIL bp_hold got=%b/%h exp=1/10", out_busy, m_data); else pass_cnt++;
    m_ready = 1'b1;
    step();
    chk_cnt++; if (out_busy !== 1'b0) $display("FAIL bp_release got=%b exp=0", out_busy); else pass_cnt++;
    repeat (3) step();
    chk_cnt++; if (sb_q.size() != 0) $display("FAIL bp_drain got=%0d exp=0", sb_q.size()); else pass_cnt++;
  endtask

  task automatic test_full_push_pop();
    do_reset();
    push_row(DW'(32'hA0));
    push_row(DW'(32'hA1));
    k_init = 1'b1;
    step();
    k_init  = 1'b0;
    k_fin   = 1'b1;
    k_data  = DW'(32'h55);
    m_ready = 1'b1;
    expect_row(k_data);
    step();
    k_fin   = 1'b0;
    m_ready = 1'b0;
    chk_cnt++; if (out_busy !== 1'b1) $display("FAIL full_pp_count got=%b exp=1", out_busy); else pass_cnt++;
    chk_cnt++; if (m_data !== DW'(32'hA1)) $display("FAIL full_pp_head got=%h exp=a1", m_data); else pass_cnt++;
    chk_cnt++; if (ovf !== 1'b0) $display("FAIL full_pp_ovf got=%b exp=0", ovf); else pass_cnt++;
    m_ready = 1'b1;
    repeat (4) step();
    chk_cnt++; if (sb_q.size() != 0 || m_valid !== 1'b0) $display("FAIL full_pp_drain got=%0d exp=0", sb_q.size()); else pass_cnt++;
  endtask

  task automatic test_overflow();
    do_reset();
    push_row(DW'(32'hB0));
    push_row(DW'(32'hB1));
    k_init = 1'b1;
    step();
    k_init = 1'b0;
    k_fin  = 1'b1;
    k_data = DW'(32'h99);
    step();
    k_fin = 1'b0;
    chk_cnt++; if (ovf !== 1'b1) $display("FAIL ovf_full got=%b exp=1", ovf); else pass_cnt++;
    repeat (5) step();
    m_ready = 1'b1;
    repeat (4) step();
    chk_cnt++; if (ovf !== 1'b1) $display("FAIL ovf_sticky got=%b exp=1", ovf); else pass_cnt++;
    chk_cnt++; if (m_valid !== 1'b0 || sb_q.size() != 0) $display("FAIL ovf_dropped got=%b exp=0", m_valid); else pass_cnt++;
    do_reset();
    chk_cnt++; if (ovf !== 1'b0) $display("FAIL ovf_cleared got=%b exp=0", ovf); else pass_cnt++;
    k_fin  = 1'b1;
    k_data = DW'(32'h77);
    expect_row(k_data);
    step();
    k_fin = 1'b0;
    chk_cnt++; if (ovf !== 1'b1) $display("FAIL ovf_no_init got=%b exp=1", ovf); else pass_cnt++;
    m_ready = 1'b1;
    repeat (3) step();
    chk_cnt++; if (sb_q.size() != 0) $display("FAIL ovf_no_init_drain got=%0d exp=0", sb_q.size()); else pass_cnt++;
  endtask

  task automatic test_two_batches();
    int f0;
    int g;
    int n;
    do_reset();
    f0 = fin_seen;
    for (int r = 0; r < 2 * ROWS; r++) begin
      g = 0;
      while (out_busy && g < 100) begin
        m_ready = 1'($urandom_range(0, 1));
        step();
        g++;
      end
      chk_cnt++; if (g >= 100) $display("FAIL tb_credit_wait got=busy exp=free"); else pass_cnt++;
      k_init  = 1'b1;
      m_ready = 1'($urandom_range(0, 1));
      step();
      k_init = 1'b0;
      n = $urandom_range(0, 2);
      repeat (n) begin
        m_ready = 1'($urandom_range(0, 1));
        step();
      end
      k_fin   = 1'b1;
      k_data  = DW'(32'h200 + r);
      m_ready = 1'($urandom_range(0, 1));
      expect_row(k_data);
      step();
      k_fin = 1'b0;
    end
    m_ready = 1'b1;
    g = 0;
    while (sb_q.size() > 0 && g < 50) begin
      step();
      g++;
    end
    step();
    step();
    chk_cnt++; if (sb_q.size() != 0) $display("FAIL tb_drain got=%0d exp=0", sb_q.size()); else pass_cnt++;
    chk_cnt++; if (fin_seen - f0 != 2) $display("FAIL tb_fin_count got=%0d exp=2", fin_seen - f0); else pass_cnt++;
  endtask

  task automatic test_reset_mid_batch();
    int f0;
    do_reset();
    push_row(DW'(32'hC0));
    k_fin  = 1'b1;
    k_data = DW'(32'hC1);
    expect_row(k_data);
    step();
    k_fin   = 1'b0;
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk_cnt++; if (ovf !== 1'b1 || m_valid !== 1'b1) $display("FAIL mid_pre got=%b/%b exp=1/1", ovf, m_valid); else pass_cnt++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb_q.delete();
    sb_row = 0;
    chk_cnt++; if (m_valid !== 1'b0)  $display("FAIL mid_m_valid got=%b exp=0", m_valid);   else pass_cnt++;
    chk_cnt++; if (out_busy !== 1'b0) $display("FAIL mid_out_busy got=%b exp=0", out_busy); else pass_cnt++;
    chk_cnt++; if (ovf !== 1'b0)      $display("FAIL mid_ovf got=%b exp=0", ovf);           else pass_cnt++;
    f0 = fin_seen;
    m_ready = 1'b1;
    for (int r = 0; r < ROWS; r++) push_row(DW'(32'hD0 + r));
    repeat (3) step();
    chk_cnt++; if (fin_seen - f0 != 1) $display("FAIL mid_fin_count got=%0d exp=1", fin_seen - f0); else pass_cnt++;
    chk_cnt++; if (sb_q.size() != 0) $display("FAIL mid_drain got=%0d exp=0", sb_q.size()); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_batch();
    test_back_pressure();
    test_full_push_pop();
    test_overflow();
    test_two_batches();
    test_reset_mid_batch();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
